// File: rtl/fpu_pkg.sv
// ============================================================================
// fpu_pkg : shared FP32 constants, rounding-mode encoding, class/entry types
// Rev 1.0
// ============================================================================
`default_nettype none

package fpu_pkg;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } rm_e;

    typedef struct packed {
        logic is_nan;
        logic is_snan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

    // Bit positions inside the {NV,DZ,OF,UF,NX} exception flag vector
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef struct packed {
        logic [31:0] num1;
        logic [31:0] num2;
        logic [2:0]  rm;
        logic        special;
        logic [31:0] special_val;
        logic [4:0]  flags;
        logic        illegal;
    } fadd_entry_t;

    function automatic logic rm_illegal(input logic [2:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fadd_operand_stage_if.sv
// ============================================================================
// fadd_operand_stage_if : request and issue handshakes of the adder operand stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface fadd_operand_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic [2:0]  in_rm;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_num1;
    logic [31:0] out_num2;
    logic [2:0]  out_rm;
    logic        out_special;
    logic [31:0] out_special_val;
    logic [4:0]  out_flags;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_rm, out_ready,
        output in_ready, out_valid, out_num1, out_num2, out_rm,
               out_special, out_special_val, out_flags, out_illegal
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, in_rm, out_ready,
        input  in_ready, out_valid, out_num1, out_num2, out_rm,
               out_special, out_special_val, out_flags, out_illegal
    );

endinterface

`default_nettype wire

// File: rtl/fp_classify.sv
// ============================================================================
// fp_classify : combinational IEEE-754 single-precision operand classifier
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_classify
    import fpu_pkg::*;
(
    input  logic [31:0] op_i,
    output fp_class_t   cls_o
);

    logic w_exp_ones;
    logic w_exp_zero;
    logic w_man_nz;
    logic w_unused_sign;

    assign w_exp_ones    = &op_i[30:23];
    assign w_exp_zero    = ~|op_i[30:23];
    assign w_man_nz      = |op_i[22:0];
    assign w_unused_sign = op_i[31];

    // Quiet bit is the mantissa MSB; a NaN with it clear is signalling
    assign cls_o.is_nan  = w_exp_ones & w_man_nz;
    assign cls_o.is_snan = w_exp_ones & w_man_nz & ~op_i[22];
    assign cls_o.is_inf  = w_exp_ones & ~w_man_nz;
    assign cls_o.is_zero = w_exp_zero & ~w_man_nz;

endmodule

`default_nettype wire

// File: rtl/fadd_operand_stage.sv
// ============================================================================
// fadd_operand_stage : decodes add/sub requests, resolves specials, buffers
//                      them in a small FIFO in front of the FP32 adder
// Rev 1.0
// ============================================================================
`default_nettype none

module fadd_operand_stage
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [2:0]            frm,
    fadd_operand_stage_if.slave   bus
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

    fadd_entry_t     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;

    logic [31:0]     w_b_eff;
    logic [2:0]      w_rm;
    fp_class_t       w_cls_a;
    fp_class_t       w_cls_b;
    fadd_entry_t     w_entry;
    fadd_entry_t     w_head;
    logic            w_push;
    logic            w_pop;
    logic            w_full;

    assign w_b_eff = {bus.in_b[31] ^ bus.in_sub, bus.in_b[30:0]};
    assign w_rm    = (bus.in_rm == DYN) ? frm : bus.in_rm;

    fp_classify u_cls_a (.op_i(bus.in_a), .cls_o(w_cls_a));
    fp_classify u_cls_b (.op_i(w_b_eff),  .cls_o(w_cls_b));

    always_comb begin
        w_entry             = '0;
        w_entry.num1        = bus.in_a;
        w_entry.num2        = w_b_eff;
        w_entry.rm          = w_rm;
        w_entry.illegal     = rm_illegal(w_rm);
        w_entry.special     = 1'b1;
        if (w_cls_a.is_nan || w_cls_b.is_nan) begin
            w_entry.special_val    = FP32_QNAN;
            w_entry.flags[FLAG_NV] = w_cls_a.is_snan | w_cls_b.is_snan;
        end else if (w_cls_a.is_inf && w_cls_b.is_inf && (bus.in_a[31] != w_b_eff[31])) begin
            w_entry.special_val    = FP32_QNAN;
            w_entry.flags[FLAG_NV] = 1'b1;
        end else if (w_cls_a.is_inf) begin
            w_entry.special_val = bus.in_a;
        end else if (w_cls_b.is_inf) begin
            w_entry.special_val = w_b_eff;
        end else if (w_cls_a.is_zero && w_cls_b.is_zero) begin
            // Exact cancellation of opposite zeros is -0 only when rounding down
            if (bus.in_a[31] == w_b_eff[31]) begin
                w_entry.special_val = {bus.in_a[31], 31'b0};
            end else begin
                w_entry.special_val = (w_rm == RDN) ? 32'h8000_0000 : 32'h0000_0000;
            end
        end else if (w_cls_a.is_zero) begin
            w_entry.special_val = w_b_eff;
        end else if (w_cls_b.is_zero) begin
            w_entry.special_val = bus.in_a;
        end else begin
            w_entry.special = 1'b0;
        end
    end

    assign w_full        = (count_q == CNT_FULL);
    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = (count_q != '0);
    assign w_push        = bus.in_valid & ~w_full;
    assign w_pop         = bus.out_valid & bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (w_push && !w_pop)      count_d = count_q + CNT_ONE;
            else if (w_pop && !w_push) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (w_push && !flush) begin
                mem_q[wr_ptr_q] <= w_entry;
            end
        end
    end

    assign w_head              = mem_q[rd_ptr_q];
    assign bus.out_num1        = w_head.num1;
    assign bus.out_num2        = w_head.num2;
    assign bus.out_rm          = w_head.rm;
    assign bus.out_special     = w_head.special;
    assign bus.out_special_val = w_head.special_val;
    assign bus.out_flags       = w_head.flags;
    assign bus.out_illegal     = w_head.illegal;

endmodule

`default_nettype wire

// File: tb/tb_fadd_operand_stage.sv
// ============================================================================
// tb_fadd_operand_stage : directed scenarios plus randomized traffic against
//                         a queue-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fadd_operand_stage;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] frm;
    int         n_cmp;
    int         n_err;

    fadd_operand_stage_if bus ();

    fadd_operand_stage #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .frm   (frm),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [105:0] act_w;
    assign act_w = {bus.out_num1, bus.out_num2, bus.out_rm, bus.out_special,
                    bus.out_special_val, bus.out_flags, bus.out_illegal};

    // Expected head payload, derived directly from the IEEE special-case rules
    function automatic logic [105:0] ref_out(input logic [31:0] a, input logic [31:0] b,
                                             input logic sub, input logic [2:0] irm,
                                             input logic [2:0] f);
        logic [31:0] bp;
        logic [31:0] val;
        logic [2:0]  rm;
        logic        sp;
        logic        nv;
        bit a_nan, a_snan, a_inf, a_zero, b_nan, b_snan, b_inf, b_zero;
        bp     = sub ? (b ^ 32'h8000_0000) : b;
        rm     = (irm == 3'd7) ? f : irm;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        a_snan = a_nan && (a[22] == 1'b0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        a_zero = (a[30:0] == 0);
        b_nan  = (bp[30:23] == 8'hFF) && (bp[22:0] != 0);
        b_snan = b_nan && (bp[22] == 1'b0);
        b_inf  = (bp[30:23] == 8'hFF) && (bp[22:0] == 0);
        b_zero = (bp[30:0] == 0);
        sp = 1'b1; nv = 1'b0; val = 32'h0;
        if (a_nan || b_nan) begin
            val = 32'h7FC0_0000; nv = a_snan || b_snan;
        end else if (a_inf && b_inf && (a[31] != bp[31])) begin
            val = 32'h7FC0_0000; nv = 1'b1;
        end else if (a_inf) val = a;
        else if (b_inf) val = bp;
        else if (a_zero && b_zero)
            val = (a[31] == bp[31]) ? {a[31], 31'b0} : ((rm == 3'd2) ? 32'h8000_0000 : 32'h0);
        else if (a_zero) val = bp;
        else if (b_zero) val = a;
        else sp = 1'b0;
        return {a, bp, rm, sp, val, nv, 4'b0000, (rm >= 3'd5)};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        logic        s;
        r = $urandom;
        s = r[31];
        case ($urandom_range(0, 6))
            0: return {s, 31'h0};
            1: return {s, 8'hFF, 23'h0};
            2: return {s, 8'hFF, 1'b1, r[21:0]};
            3: return {s, 8'hFF, 1'b0, r[21:1], 1'b1};
            default: return r;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [2:0] rm);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_rm    = rm;
    endtask

    task automatic test_reset();
        step();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        n_cmp++;
        if (act_w !== '0) begin
            n_err++;
            $display("FAIL reset_payload: got %h required 0", act_w);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_normal_add();
        bus.out_ready = 1'b0;
        drive(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'b000);
        step();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_num1 !== 32'h3F80_0000 || bus.out_num2 !== 32'h4000_0000
            || bus.out_special !== 1'b0 || bus.out_rm !== 3'b000) begin
            n_err++;
            $display("FAIL normal_add: valid=%b num1=%h num2=%h special=%b rm=%b required 1/3f800000/40000000/0/000",
                     bus.out_valid, bus.out_num1, bus.out_num2, bus.out_special, bus.out_rm);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL normal_drain: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_dyn_rm();
        frm = 3'b011;
        drive(32'h3F80_0000, 32'h4000_0000, 1'b1, 3'b111);
        step();
        bus.in_valid = 1'b0;
        frm = 3'b000;
        n_cmp++;
        if (bus.out_num2 !== 32'hC000_0000 || bus.out_rm !== 3'b011 || bus.out_illegal !== 1'b0) begin
            n_err++;
            $display("FAIL dyn_rm_sub: num2=%h rm=%b illegal=%b required c0000000/011/0",
                     bus.out_num2, bus.out_rm, bus.out_illegal);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        drive(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'b101);
        step();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_illegal !== 1'b1 || bus.out_rm !== 3'b101) begin
            n_err++;
            $display("FAIL illegal_rm: illegal=%b rm=%b required 1/101", bus.out_illegal, bus.out_rm);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_specials();
        logic [31:0] ta [7];
        logic [31:0] tb [7];
        logic        ts [7];
        logic [2:0]  tr [7];
        logic [31:0] tv [7];
        logic        tn [7];
        ta = '{32'h7F80_0000, 32'h7F80_0001, 32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
        tb = '{32'h7F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h8000_0000, 32'h0000_0000};
        ts = '{1'b1,          1'b0,          1'b0,          1'b0,          1'b1,          1'b0,          1'b1};
        tr = '{3'b000,        3'b000,        3'b000,        3'b000,        3'b000,        3'b010,        3'b000};
        tv = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'hC000_0000, 32'h8000_0000, 32'h8000_0000};
        tn = '{1'b1,          1'b1,          1'b0,          1'b0,          1'b0,          1'b0,          1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(ta[i], tb[i], ts[i], tr[i]);
            step();
            bus.in_valid = 1'b0;
            n_cmp++;
            if (bus.out_special !== 1'b1 || bus.out_special_val !== tv[i] || bus.out_flags !== {tn[i], 4'b0000}) begin
                n_err++;
                $display("FAIL special_%0d: special=%b val=%h flags=%b required 1/%h/%b",
                         i, bus.out_special, bus.out_special_val, bus.out_flags, tv[i], {tn[i], 4'b0000});
            end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
        drive(32'h0000_0000, 32'h8000_0000, 1'b0, 3'b000);
        step();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_special_val !== 32'h0000_0000 || bus.out_special !== 1'b1) begin
            n_err++;
            $display("FAIL zero_rne: special=%b val=%h required 1/00000000", bus.out_special, bus.out_special_val);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(32'h3F80_0000 + 32'(i), 32'h4000_0000, 1'b0, 3'b000);
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_num1 !== 32'h3F80_0000) begin
            n_err++;
            $display("FAIL full: in_ready=%b out_valid=%b num1=%h required 0/1/3f800000",
                     bus.in_ready, bus.out_valid, bus.out_num1);
        end
        step();
        n_cmp++;
        if (bus.out_num1 !== 32'h3F80_0000 || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL head_stable: num1=%h valid=%b required 3f800000/1", bus.out_num1, bus.out_valid);
        end
        drive(32'h3F80_00AA, 32'h4000_0000, 1'b0, 3'b000);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_num1 !== 32'h3F80_0001 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_push_pop: num1=%h in_ready=%b required 3f800001/1", bus.out_num1, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_no_push: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        drive(32'h4040_0000, 32'h4000_0000, 1'b0, 3'b000);
        step();
        drive(32'h4080_0000, 32'h4000_0000, 1'b0, 3'b000);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_lost: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_rst_mid();
        drive(32'h40A0_0000, 32'h4000_0000, 1'b0, 3'b000);
        step();
        drive(32'h40C0_0000, 32'h4000_0000, 1'b0, 3'b000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_num1 !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid: out_valid=%b in_ready=%b num1=%h required 0/1/0",
                     bus.out_valid, bus.in_ready, bus.out_num1);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_lost: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [105:0] q[$];
        logic         v, r, fl;
        logic [31:0]  a, b;
        logic         s;
        logic [2:0]   rm;
        int           sz;
        for (int cyc = 0; cyc < 500; cyc++) begin
            n_cmp++;
            if (bus.in_ready !== (q.size() < DEPTH) || bus.out_valid !== (q.size() != 0)) begin
                n_err++;
                $display("FAIL rand_hs cyc %0d: in_ready=%b out_valid=%b model size %0d",
                         cyc, bus.in_ready, bus.out_valid, q.size());
            end
            if (q.size() != 0) begin
                n_cmp++;
                if (act_w !== q[0]) begin
                    n_err++;
                    $display("FAIL rand_head cyc %0d: got %h required %h", cyc, act_w, q[0]);
                end
            end
            v  = ($urandom_range(0, 99) < 60);
            r  = ($urandom_range(0, 99) < 55);
            fl = ($urandom_range(0, 99) < 4);
            a  = rand_op();
            b  = rand_op();
            s  = 1'($urandom_range(0, 1));
            rm = 3'($urandom_range(0, 7));
            frm = 3'($urandom_range(0, 7));
            bus.in_valid  = v;
            bus.in_a      = a;
            bus.in_b      = b;
            bus.in_sub    = s;
            bus.in_rm     = rm;
            bus.out_ready = r;
            flush         = fl;
            sz = q.size();
            if (fl) begin
                q.delete();
            end else begin
                if (r && sz != 0) void'(q.pop_front());
                if (v && sz < DEPTH) q.push_back(ref_out(a, b, s, rm, frm));
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk = 1'b0;
        rst = 1'b1;
        flush = 1'b0;
        frm = 3'b000;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_rm     = 3'b000;
        bus.out_ready = 1'b0;
        test_reset();
        test_normal_add();
        test_dyn_rm();
        test_specials();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
